// File: rtl/inv_mix_column_seq.sv
// Column-serial InvMixColumns engine for the AES decrypt round path.
// NUM_MUL column multipliers are time-shared across the four 32-bit state columns,
// so a block takes 4/NUM_MUL RUN cycles. Bypass blocks skip the multipliers.
module inv_mix_column_seq #(
  parameter int unsigned NUM_MUL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic         bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  localparam int unsigned N_STEP = 4 / NUM_MUL;
  localparam int unsigned StepW  = (N_STEP > 1) ? $clog2(N_STEP) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e             state_q, state_d;
  logic [StepW-1:0]   step_q, step_d;
  logic [127:0]       src_buf_q, src_buf_d;
  logic [127:0]       dst_buf_q, dst_buf_d;

  logic [31:0] mul_in  [NUM_MUL];
  logic [31:0] mul_out [NUM_MUL];

  // GF(2^8) doubling, reduction polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One InvMixColumns column: rows of the circulant {0e,0b,0d,09}; byte 0 is the MSB.
  function automatic logic [31:0] inverse_matrix_mul(input logic [31:0] col);
    logic [7:0] s  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      s[i]  = col[31-8*i -: 8];
      x2    = xtime(s[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ s[i];
      mb[i] = x8 ^ x2 ^ s[i];
      md[i] = x8 ^ x4 ^ s[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Route the columns selected by the current step from src_buf to the multipliers.
  always_comb begin
    for (int unsigned m = 0; m < NUM_MUL; m++) begin
      mul_in[m] = src_buf_q[127 - 32*(int'(step_q)*NUM_MUL + m) -: 32];
    end
  end

  for (genvar g = 0; g < NUM_MUL; g++) begin : g_mul
    assign mul_out[g] = inverse_matrix_mul(mul_in[g]);
  end

  // Next-state logic: accept in IDLE, one column group per RUN cycle, hold for handshake.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    src_buf_d = src_buf_q;
    dst_buf_d = dst_buf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          src_buf_d = data_in;
          if (bypass) begin
            dst_buf_d = data_in;
            state_d   = StHold;
          end else begin
            step_d  = '0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        for (int unsigned m = 0; m < NUM_MUL; m++) begin
          dst_buf_d[127 - 32*(int'(step_q)*NUM_MUL + m) -: 32] = mul_out[m];
        end
        if (step_q == StepW'(N_STEP - 1)) begin
          state_d = StHold;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset; reset drops any block in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      step_q    <= '0;
      src_buf_q <= '0;
      dst_buf_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      src_buf_q <= src_buf_d;
      dst_buf_q <= dst_buf_d;
    end
  end

  // Outputs decode directly from the state register.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StHold);
    busy      = (state_q != StIdle);
    data_out  = dst_buf_q;
  end

endmodule
